// File: rtl/cluster_rst_seq_pkg.sv
// cluster_rst_seq_pkg: shared state encodings, debug hold length and width helpers for the cluster reset sequencer
package cluster_rst_seq_pkg;
  typedef enum logic [2:0] {
    S_RESET,
    S_CKEN_RAMP,
    S_RST_HOLD,
    S_RUN,
    S_DRAIN,
    S_DBG_PULSE,
    S_DBG_HOLD
  } seq_state_t;

  localparam int DBG_HOLD_CYC = 2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a > b ? a : b;
    return m > c ? m : c;
  endfunction
endpackage

// File: rtl/cluster_rst_seq_timer.sv
// rst_seq_timer: loadable down-counter saturating at zero, shared by the stagger, hold and pulse intervals
//   gclk, arst_l : clock and async active-low reset
//   load         : strobe, takes load_val on this edge
//   load_val     : interval length minus one
//   zero         : counter is at zero
module rst_seq_timer #(
  parameter int W = 5
) (
  input  logic         gclk,
  input  logic         arst_l,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt;

  always_ff @(posedge gclk or negedge arst_l)
    if (!arst_l) cnt <= '0;
    else cnt <= load ? load_val : (cnt == '0 ? cnt : cnt - 1'b1);

  assign zero = cnt == '0;
endmodule

// File: rtl/cluster_rst_seq.sv
// cluster_rst_seq: staggered cluster clock ramp, global reset hold, warm reset and debug init sequencing
//   gclk, arst_l  : clock and async active-low reset
//   wrm_rst_req   : warm reset request pulse
//   dbg_init_req  : debug init request pulse
//   cken_mask     : software cluster clock enable mask, honoured in RUN
//   cluster_cken  : per-cluster clock enables
//   grst_l        : global reset, active low
//   gdbginit_l    : global debug init, active low
//   seq_busy      : sequencer not in RUN
module cluster_rst_seq
  import cluster_rst_seq_pkg::*;
#(
  parameter int NCLUS     = 4,
  parameter int STAGGER   = 8,
  parameter int RST_HOLD  = 16,
  parameter int DBG_PULSE = 8
) (
  input  logic             gclk,
  input  logic             arst_l,
  input  logic             wrm_rst_req,
  input  logic             dbg_init_req,
  input  logic [NCLUS-1:0] cken_mask,
  output logic [NCLUS-1:0] cluster_cken,
  output logic             grst_l,
  output logic             gdbginit_l,
  output logic             seq_busy
);
  localparam int TW = clog2(max3(STAGGER, RST_HOLD, DBG_PULSE)) + 1;
  localparam int IW = clog2(NCLUS) + 1;
  localparam logic [IW-1:0] LAST = IW'(NCLUS);

  seq_state_t    state;
  logic [IW-1:0] idx;
  logic          wrm_q, dbg_q;
  logic          tz, ld;
  logic [TW-1:0] ld_val;
  logic          wrm_go, hold_reload, dbg_go, ramp_step, ramp_done;

  // Requests are registered and qualified by the state they were sampled in,
  // so the sequencer reacts one edge after the sampling edge.
  always_comb begin
    wrm_go      = wrm_q && (state == S_RUN || state == S_DBG_PULSE || state == S_DBG_HOLD);
    hold_reload = wrm_q && state == S_RST_HOLD;
    dbg_go      = dbg_q && !wrm_q && state == S_RUN;
    ramp_step   = state == S_CKEN_RAMP && tz && idx < LAST;
    ramp_done   = state == S_CKEN_RAMP && tz && idx == LAST;
    ld          = state == S_RESET || ramp_step || ramp_done || hold_reload || state == S_DRAIN ||
                  dbg_go || (state == S_DBG_PULSE && tz && !wrm_go);
    ld_val      = state == S_RESET ? '0 :
                  ramp_step ? TW'(STAGGER - 1) :
                  dbg_go ? TW'(DBG_PULSE - 1) :
                  state == S_DBG_PULSE ? TW'(DBG_HOLD_CYC - 1) : TW'(RST_HOLD - 1);
  end

  rst_seq_timer #(.W(TW)) u_timer (
    .gclk     (gclk),
    .arst_l   (arst_l),
    .load     (ld),
    .load_val (ld_val),
    .zero     (tz)
  );

  always_ff @(posedge gclk or negedge arst_l)
    if (!arst_l) begin
      state        <= S_RESET;
      idx          <= '0;
      wrm_q        <= 1'b0;
      dbg_q        <= 1'b0;
      cluster_cken <= '0;
      grst_l       <= 1'b0;
      gdbginit_l   <= 1'b0;
      seq_busy     <= 1'b1;
    end else begin
      wrm_q <= wrm_rst_req && (state inside {S_RUN, S_RST_HOLD, S_DBG_PULSE, S_DBG_HOLD});
      dbg_q <= dbg_init_req && !wrm_rst_req && state == S_RUN;
      if (wrm_go) begin
        state        <= S_DRAIN;
        cluster_cken <= '1;
        grst_l       <= 1'b0;
        gdbginit_l   <= 1'b0;
        seq_busy     <= 1'b1;
      end else
        case (state)
          S_RESET: begin
            state <= S_CKEN_RAMP;
            idx   <= '0;
          end
          S_CKEN_RAMP:
            if (ramp_step) begin
              cluster_cken <= cluster_cken | (NCLUS'(1) << idx);
              idx          <= idx + 1'b1;
            end else if (ramp_done) begin
              state        <= S_RST_HOLD;
              cluster_cken <= '1;
            end
          S_DRAIN: state <= S_RST_HOLD;
          // Headers need rclk running while reset propagates, so cken stays
          // all-ones for the first RUN cycle and the mask lands one edge later.
          S_RST_HOLD:
            if (tz && !hold_reload) begin
              state      <= S_RUN;
              grst_l     <= 1'b1;
              gdbginit_l <= 1'b1;
              seq_busy   <= 1'b0;
            end
          S_RUN:
            if (dbg_go) begin
              state        <= S_DBG_PULSE;
              cluster_cken <= '1;
              gdbginit_l   <= 1'b0;
              seq_busy     <= 1'b1;
            end else
              cluster_cken <= cken_mask;
          S_DBG_PULSE:
            if (tz) begin
              state      <= S_DBG_HOLD;
              gdbginit_l <= 1'b1;
            end
          S_DBG_HOLD:
            if (tz) begin
              state        <= S_RUN;
              cluster_cken <= cken_mask;
              seq_busy     <= 1'b0;
            end
          default: state <= S_RESET;
        endcase
    end
endmodule
